id_stage: RTL

//  Decode stage of the 5-stage MIPS pipeline; consumes IF/ID outputs, drives IF's PC-select/stall/flush controls.

---
 rtl/id_stage_pkg.sv | 118 +++++++++++
 rtl/id_stage_reg_file.sv | 54 +++++
 rtl/id_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared MIPS decode definitions for the ID stage: opcode/funct encodings,
// ALU op codes, control bundle and the instruction decoder.
package id_stage_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2A
    } funct_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_t alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  uses_rs;
        logic  uses_rt;
        logic  sign_ext;
        logic  is_beq;
        logic  is_bne;
        logic  is_j;
    } decode_t;

    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d          = '0;
        d.sign_ext = 1'b1;
        case (instr[31:26])
            OP_RTYPE: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.reg_dst   = 1'b1;
                d.uses_rs        = 1'b1;
                d.uses_rt        = 1'b1;
                case (instr[5:0])
                    FN_ADD:  d.ctrl.alu_op = ALU_ADD;
                    FN_SUB:  d.ctrl.alu_op = ALU_SUB;
                    FN_AND:  d.ctrl.alu_op = ALU_AND;
                    FN_OR:   d.ctrl.alu_op = ALU_OR;
                    FN_SLT:  d.ctrl.alu_op = ALU_SLT;
                    default: begin
                        d.ctrl    = '0;
                        d.uses_rs = 1'b0;
                        d.uses_rt = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.alu_src    = 1'b1;
                d.uses_rs         = 1'b1;
            end
            OP_SW: begin
                d.ctrl.mem_write = 1'b1;
                d.ctrl.alu_src   = 1'b1;
                d.uses_rs        = 1'b1;
                d.uses_rt        = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_src   = 1'b1;
                d.uses_rs        = 1'b1;
                case (instr[31:26])
                    OP_SLTI: d.ctrl.alu_op = ALU_SLT;
                    OP_ANDI: d.ctrl.alu_op = ALU_AND;
                    OP_ORI:  d.ctrl.alu_op = ALU_OR;
                    default: d.ctrl.alu_op = ALU_ADD;
                endcase
                d.sign_ext = !(instr[31:26] == OP_ANDI || instr[31:26] == OP_ORI);
            end
            OP_BEQ, OP_BNE: begin
                // Resolved here; EX only sees a harmless SUB with no side effects.
                d.ctrl.alu_op = ALU_SUB;
                d.uses_rs     = 1'b1;
                d.uses_rt     = 1'b1;
                d.is_beq      = (instr[31:26] == OP_BEQ);
                d.is_bne      = (instr[31:26] == OP_BNE);
            end
            OP_J:    d.is_j = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file with synchronous clear and same-cycle
// writeback bypass; entry 0 always reads zero.
module reg_file
    import id_stage_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != AW'(REG_ZERO));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == AW'(REG_ZERO)) begin
            rd1 = '0;
        end else if (wr_en && wa == ra1) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == AW'(REG_ZERO)) begin
            rd2 = '0;
        end else if (wr_en && wa == ra2) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: register file, control decode, ID-resolved branches and
// jumps, hazard stalls toward IF, and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] IFIDPCPlus4,
    input  logic [31:0]     IDInstr,
    input  logic [XLEN-1:0] IFPCPlus4Out,
    output logic [XLEN-1:0] IDJumpTarget,
    output logic [XLEN-1:0] IDNonJumpTarget,
    output logic            IDJump,
    output logic            IFIDFlush,
    output logic            IFIDWrite,
    output logic            IFPCWrite,
    input  logic            EXMemRead,
    input  logic            EXRegWrite,
    input  logic [4:0]      EXWriteReg,
    input  logic            MEMMemRead,
    input  logic            MEMRegWrite,
    input  logic [4:0]      MEMWriteReg,
    input  logic [XLEN-1:0] MEMALUResult,
    input  logic            WBRegWrite,
    input  logic [4:0]      WBWriteReg,
    input  logic [XLEN-1:0] WBWriteData,
    output logic [XLEN-1:0] IDEXPCPlus4,
    output logic [XLEN-1:0] IDEXReadData1,
    output logic [XLEN-1:0] IDEXReadData2,
    output logic [XLEN-1:0] IDEXImm,
    output logic [4:0]      IDEXRs,
    output logic [4:0]      IDEXRt,
    output logic [4:0]      IDEXRd,
    output logic            IDEXRegWrite,
    output logic            IDEXMemRead,
    output logic            IDEXMemWrite,
    output logic            IDEXMemtoReg,
    output logic            IDEXALUSrc,
    output logic            IDEXRegDst,
    output logic [2:0]      IDEXALUOp
);

    decode_t         dec;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] cmp_a, cmp_b;
    logic [XLEN-1:0] branch_target, jump_target;
    logic            rs_live, rt_live, is_branch;
    logic            ex_hit, mem_hit;
    logic            stall, taken, redirect;
    ctrl_t           idex_ctrl;

    assign rs = IDInstr[25:21];
    assign rt = IDInstr[20:16];
    assign rd = IDInstr[15:11];

    reg_file #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_reg_file (
        .clock (clock),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (WBRegWrite),
        .wa    (WBWriteReg),
        .wd    (WBWriteData)
    );

    always_comb begin
        dec       = decode(IDInstr);
        is_branch = dec.is_beq || dec.is_bne;
        imm_ext   = dec.sign_ext ? {{(XLEN-16){IDInstr[15]}}, IDInstr[15:0]}
                                 : {{(XLEN-16){1'b0}}, IDInstr[15:0]};

        rs_live = dec.uses_rs && (rs != REG_ZERO);
        rt_live = dec.uses_rt && (rt != REG_ZERO);
        ex_hit  = (rs_live && EXWriteReg == rs)  || (rt_live && EXWriteReg == rt);
        mem_hit = (rs_live && MEMWriteReg == rs) || (rt_live && MEMWriteReg == rt);

        // Reset masks the stall so IF keeps running; it is re-derived once reset drops.
        stall = !reset && ((EXMemRead && ex_hit)
                        || (is_branch && EXRegWrite && ex_hit)
                        || (is_branch && MEMMemRead && mem_hit));

        // Only ALU results can be forwarded from MEM; a MEM load stalls instead.
        cmp_a = (MEMRegWrite && !MEMMemRead && MEMWriteReg == rs && rs != REG_ZERO)
              ? MEMALUResult : rf_rd1;
        cmp_b = (MEMRegWrite && !MEMMemRead && MEMWriteReg == rt && rt != REG_ZERO)
              ? MEMALUResult : rf_rd2;

        taken         = (dec.is_beq && cmp_a == cmp_b) || (dec.is_bne && cmp_a != cmp_b);
        branch_target = IFIDPCPlus4 + (imm_ext << 2);
        jump_target   = {IFIDPCPlus4[XLEN-1:28], IDInstr[25:0], 2'b00};
        redirect      = !reset && !stall && (dec.is_j || taken);
    end

    assign IDJumpTarget    = dec.is_j ? jump_target : branch_target;
    assign IDNonJumpTarget = IFPCPlus4Out;
    assign IDJump          = redirect;
    assign IFIDFlush       = redirect;
    assign IFIDWrite       = !stall;
    assign IFPCWrite       = !stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            IDEXPCPlus4   <= '0;
            IDEXReadData1 <= '0;
            IDEXReadData2 <= '0;
            IDEXImm       <= '0;
            IDEXRs        <= '0;
            IDEXRt        <= '0;
            IDEXRd        <= '0;
            idex_ctrl     <= '0;
        end else begin
            IDEXPCPlus4   <= IFIDPCPlus4;
            IDEXReadData1 <= rf_rd1;
            IDEXReadData2 <= rf_rd2;
            IDEXImm       <= imm_ext;
            IDEXRs        <= rs;
            IDEXRt        <= rt;
            IDEXRd        <= rd;
            idex_ctrl     <= stall ? '0 : dec.ctrl;
        end
    end

    assign IDEXRegWrite = idex_ctrl.reg_write;
    assign IDEXMemRead  = idex_ctrl.mem_read;
    assign IDEXMemWrite = idex_ctrl.mem_write;
    assign IDEXMemtoReg = idex_ctrl.mem_to_reg;
    assign IDEXALUSrc   = idex_ctrl.alu_src;
    assign IDEXRegDst   = idex_ctrl.reg_dst;
    assign IDEXALUOp    = idex_ctrl.alu_op;

endmodule
